// File: rtl/emif_lb_arbiter_pkg.sv
// Shared widths and arbiter state encoding for the linebuffer EMIF arbiter.
package emif_arb_pkg;

  localparam int EMIF_MAXBURST = 32;
  localparam int EMIF_ADDR_W   = 28;
  localparam int EMIF_DATA_W   = 256;
  localparam int EMIF_BC_W     = 6;
  localparam int RD_CNT_W      = 7;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_RD_CMD   = 2'd1,
    ARB_WR_BURST = 2'd2
  } arb_state_e;

endpackage

// File: rtl/emif_lb_arbiter_if.sv
// Avalon-MM style burst port; the same bundle serves the two slave ports and the bridge master port.
interface emif_lb_arbiter_if;
  import emif_arb_pkg::*;

  logic [EMIF_ADDR_W-1:0] addr;
  logic                   read;
  logic                   write;
  logic [EMIF_DATA_W-1:0] wdata;
  logic [EMIF_BC_W-1:0]   burstcount;
  logic                   waitrequest;
  logic [EMIF_DATA_W-1:0] rdata;
  logic                   readdatavalid;

  modport master (
    output addr, read, write, wdata, burstcount,
    input  waitrequest, rdata, readdatavalid
  );

  modport slave (
    input  addr, read, write, wdata, burstcount,
    output waitrequest, rdata, readdatavalid
  );

endinterface

// File: rtl/emif_lb_arbiter_rd_tracker.sv
// Outstanding read-beat counter with admission compare and sticky underflow flag.
module emif_rd_tracker
  import emif_arb_pkg::*;
#(
  parameter int MAX_RD_BEATS = 64
) (
  input  logic                 emif_br_clk,
  input  logic                 reset_n,
  input  logic                 cmd_accept,
  input  logic [EMIF_BC_W-1:0] req_bc,
  input  logic                 readdatavalid,
  output logic [RD_CNT_W-1:0]  outstanding,
  output logic                 req_fits,
  output logic                 err_underflow
);

  localparam logic [RD_CNT_W:0] BEAT_LIMIT = (RD_CNT_W + 1)'(MAX_RD_BEATS);

  logic [RD_CNT_W:0]   req_sum;
  logic [RD_CNT_W-1:0] add_beats;
  logic [RD_CNT_W-1:0] cnt_nxt;
  logic                underflow;

  assign req_sum   = {1'b0, outstanding} + {{(RD_CNT_W + 1 - EMIF_BC_W){1'b0}}, req_bc};
  assign req_fits  = (req_sum <= BEAT_LIMIT);
  assign add_beats = cmd_accept ? {{(RD_CNT_W - EMIF_BC_W){1'b0}}, req_bc} : '0;
  assign underflow = readdatavalid && (outstanding == '0);

  // A stray return beat at zero is flagged and dropped rather than wrapping the count.
  always_comb begin
    cnt_nxt = outstanding + add_beats;
    if (readdatavalid && !underflow) begin
      cnt_nxt = cnt_nxt - RD_CNT_W'(1);
    end
  end

  always_ff @(posedge emif_br_clk or negedge reset_n) begin
    if (!reset_n) begin
      outstanding   <= '0;
      err_underflow <= 1'b0;
    end else begin
      outstanding <= cnt_nxt;
      if (underflow) begin
        err_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/emif_lb_arbiter.sv
// Read-priority arbiter sharing one EMIF bridge port between linebuffer write and read masters.
//   state    | meaning
//   IDLE     | no grant; both slaves stalled
//   RD_CMD   | read master owns the port for one command
//   WR_BURST | write master owns the port until its last beat is accepted
module emif_lb_arbiter
  import emif_arb_pkg::*;
#(
  parameter int WR_STARVE_LIMIT = 2,
  parameter int MAX_RD_BEATS    = 64
) (
  input  logic                    emif_br_clk,
  input  logic                    reset_n,
  emif_lb_arbiter_if.slave        wr,
  emif_lb_arbiter_if.slave        rd,
  emif_lb_arbiter_if.master       m,
  output logic [RD_CNT_W-1:0]     rd_outstanding
);

  localparam logic [1:0] IDLE     = ARB_IDLE;
  localparam logic [1:0] RD_CMD   = ARB_RD_CMD;
  localparam logic [1:0] WR_BURST = ARB_WR_BURST;

  localparam int                  STREAK_W   = $clog2(WR_STARVE_LIMIT + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(WR_STARVE_LIMIT);

  logic [1:0]           state;
  logic [STREAK_W-1:0]  rd_streak;
  logic [EMIF_BC_W-1:0] beats_left;
  logic                 wr_pend_at_grant;
  logic                 rd_fits;
  logic                 rq_r;
  logic                 rq_w;
  logic                 rd_cmd_accept;
  logic                 wr_beat;
  logic                 err_underflow;
  logic                 unused_sink;

  assign rq_r = rd.read && (rd.burstcount != '0) && rd_fits;
  assign rq_w = wr.write && (wr.burstcount != '0);

  assign rd_cmd_accept = (state == RD_CMD) && rd.read && !m.waitrequest;
  assign wr_beat       = (state == WR_BURST) && wr.write && !m.waitrequest;

  emif_rd_tracker #(
    .MAX_RD_BEATS (MAX_RD_BEATS)
  ) u_rd_tracker (
    .emif_br_clk   (emif_br_clk),
    .reset_n       (reset_n),
    .cmd_accept    (rd_cmd_accept),
    .req_bc        (rd.burstcount),
    .readdatavalid (m.readdatavalid),
    .outstanding   (rd_outstanding),
    .req_fits      (rd_fits),
    .err_underflow (err_underflow)
  );

  always_ff @(posedge emif_br_clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      rd_streak        <= '0;
      beats_left       <= '0;
      wr_pend_at_grant <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Reads win unless a pending write has already waited out its streak.
          if (rq_r && (!rq_w || (rd_streak < STREAK_MAX))) begin
            state            <= RD_CMD;
            wr_pend_at_grant <= rq_w;
          end else if (rq_w) begin
            state      <= WR_BURST;
            beats_left <= wr.burstcount;
          end
        end
        RD_CMD: begin
          if (!m.waitrequest) begin
            state <= IDLE;
            if (wr_pend_at_grant && (rd_streak < STREAK_MAX)) begin
              rd_streak <= rd_streak + STREAK_W'(1);
            end
          end
        end
        WR_BURST: begin
          if (wr_beat) begin
            beats_left <= beats_left - EMIF_BC_W'(1);
            if (beats_left == EMIF_BC_W'(1)) begin
              state     <= IDLE;
              rd_streak <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    m.read         = 1'b0;
    m.write        = 1'b0;
    m.addr         = '0;
    m.wdata        = '0;
    m.burstcount   = '0;
    wr.waitrequest = 1'b1;
    rd.waitrequest = 1'b1;
    case (state)
      RD_CMD: begin
        m.read         = rd.read;
        m.addr         = rd.addr;
        m.burstcount   = rd.burstcount;
        rd.waitrequest = m.waitrequest;
      end
      WR_BURST: begin
        m.write        = wr.write;
        m.addr         = wr.addr;
        m.wdata        = wr.wdata;
        m.burstcount   = wr.burstcount;
        wr.waitrequest = m.waitrequest;
      end
      default: ;
    endcase
  end

  assign rd.rdata         = m.rdata;
  assign rd.readdatavalid = m.readdatavalid;
  assign wr.rdata         = '0;
  assign wr.readdatavalid = 1'b0;

  // Slave-side fields with no meaning on their port, plus the debug-only underflow flag.
  assign unused_sink = ^{wr.read, rd.write, rd.wdata, err_underflow};

endmodule

// File: tb/tb_emif_lb_arbiter.sv
// Directed bench for emif_lb_arbiter: cycle table for arbitration plus multi-cycle corner sequences.
module tb_emif_lb_arbiter;
  import emif_arb_pkg::*;

  localparam logic [27:0]  RD_ADDR = 28'h0A5_0000;
  localparam logic [27:0]  WR_ADDR = 28'h012_3456;
  localparam logic [255:0] WDATA   = {8{32'hDEAD_BEEF}};

  typedef struct packed {
    logic       rr;
    logic       ww;
    logic       mw;
    logic       rdv;
    logic [1:0] sel;
    logic [6:0] cnt;
  } vec_t;

  logic       emif_br_clk = 1'b0;
  logic       reset_n;
  logic [6:0] rd_outstanding;
  int         checks   = 0;
  int         failures = 0;

  vec_t vecs [16];

  emif_lb_arbiter_if wr_if ();
  emif_lb_arbiter_if rd_if ();
  emif_lb_arbiter_if m_if ();

  emif_lb_arbiter #(
    .WR_STARVE_LIMIT (2),
    .MAX_RD_BEATS    (64)
  ) dut (
    .emif_br_clk    (emif_br_clk),
    .reset_n        (reset_n),
    .wr             (wr_if),
    .rd             (rd_if),
    .m              (m_if),
    .rd_outstanding (rd_outstanding)
  );

  always #5 emif_br_clk = ~emif_br_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  function automatic vec_t mkv(input logic rr, input logic ww, input logic mw, input logic rdv,
                               input logic [1:0] sel, input logic [6:0] cnt);
    vec_t v;
    v.rr = rr; v.ww = ww; v.mw = mw; v.rdv = rdv; v.sel = sel; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [599:0] act, input logic [599:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    wr_if.addr = WR_ADDR; wr_if.read = 1'b0; wr_if.write = 1'b0; wr_if.wdata = WDATA;
    wr_if.burstcount = 6'd0;
    rd_if.addr = RD_ADDR; rd_if.read = 1'b0; rd_if.write = 1'b0; rd_if.wdata = '0;
    rd_if.burstcount = 6'd0;
    m_if.waitrequest = 1'b0; m_if.rdata = '0; m_if.readdatavalid = 1'b0;
  endtask

  task automatic next_cyc();
    @(posedge emif_br_clk);
    #1;
  endtask

  // Leaves the bench at the start of the first post-reset cycle (posedge + 1).
  task automatic do_reset();
    reset_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge emif_br_clk);
    #1 reset_n = 1'b1;
  endtask

  function automatic logic [17:0] ctrl_now();
    return {m_if.read, m_if.write, m_if.burstcount, wr_if.waitrequest, rd_if.waitrequest,
            rd_outstanding, rd_if.readdatavalid};
  endfunction

  localparam logic [17:0] CTRL_RESET = {1'b0, 1'b0, 6'd0, 1'b1, 1'b1, 7'd0, 1'b0};

  int beats, stalls, wcyc, rd_leak, wait_bad, wr_seen, rd_seen, wrw_bad;

  initial begin
    // Table: rd bc=4 and wr bc=2 both pending; expected R,R,W,R,R,W with a read stall and returns during write.
    vecs[0]  = mkv(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 7'd0);
    vecs[1]  = mkv(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 7'd0);
    vecs[2]  = mkv(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 7'd4);
    vecs[3]  = mkv(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 7'd4);
    vecs[4]  = mkv(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 7'd8);
    vecs[5]  = mkv(1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 7'd8);
    vecs[6]  = mkv(1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 7'd8);
    vecs[7]  = mkv(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 7'd8);
    vecs[8]  = mkv(1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 7'd8);
    vecs[9]  = mkv(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 7'd8);
    vecs[10] = mkv(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 7'd12);
    vecs[11] = mkv(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 7'd12);
    vecs[12] = mkv(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 7'd16);
    vecs[13] = mkv(1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 7'd16);
    vecs[14] = mkv(1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 7'd15);
    vecs[15] = mkv(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 7'd14);

    // Reset values, observed while reset is held.
    reset_n = 1'b1;
    clear_inputs();
    #2 reset_n = 1'b0;
    #1;
    chk("reset_ctrl", ctrl_now(), CTRL_RESET);
    chk("reset_addr_data", {m_if.addr, m_if.wdata, rd_if.rdata}, '0);
    repeat (2) @(posedge emif_br_clk);
    #1 reset_n = 1'b1;

    // Table-driven arbitration sequence.
    for (int i = 0; i < 16; i++) begin
      logic [17:0]  exp_ctrl;
      logic [255:0] rdat;
      logic [27:0]  e_addr;
      logic [255:0] e_wdata;
      logic [5:0]   e_bc;
      if (i > 0) next_cyc();
      rdat = {8{32'h1000 + 32'(i)}};
      rd_if.read = vecs[i].rr; rd_if.burstcount = 6'd4;
      wr_if.write = vecs[i].ww; wr_if.burstcount = 6'd2;
      m_if.waitrequest = vecs[i].mw; m_if.readdatavalid = vecs[i].rdv; m_if.rdata = rdat;
      @(negedge emif_br_clk);
      e_bc    = (vecs[i].sel == 2'd1) ? 6'd4 : (vecs[i].sel == 2'd2) ? 6'd2 : 6'd0;
      e_addr  = (vecs[i].sel == 2'd1) ? RD_ADDR : (vecs[i].sel == 2'd2) ? WR_ADDR : 28'd0;
      e_wdata = (vecs[i].sel == 2'd2) ? WDATA : '0;
      exp_ctrl = {(vecs[i].sel == 2'd1), (vecs[i].sel == 2'd2), e_bc,
                  (vecs[i].sel == 2'd2) ? vecs[i].mw : 1'b1,
                  (vecs[i].sel == 2'd1) ? vecs[i].mw : 1'b1,
                  vecs[i].cnt, vecs[i].rdv};
      chk($sformatf("vec%0d_ctrl", i), ctrl_now(), exp_ctrl);
      chk($sformatf("vec%0d_data", i), {m_if.addr, m_if.wdata, rd_if.rdata}, {e_addr, e_wdata, rdat});
    end

    // Reads of 32 beats: grants two cycles apart, peak 64, third read held until 32 beats return.
    do_reset();
    rd_if.read = 1'b1; rd_if.burstcount = 6'd32;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) next_cyc();
      @(negedge emif_br_clk);
      chk($sformatf("rd32_grant_c%0d", i), m_if.read, (i % 2 == 1));
    end
    next_cyc();
    @(negedge emif_br_clk);
    chk("rd32_peak", {m_if.read, rd_outstanding}, {1'b0, 7'd64});
    rd_leak = 0;
    for (int k = 0; k < 32; k++) begin
      next_cyc();
      m_if.readdatavalid = 1'b1;
      @(negedge emif_br_clk);
      if (m_if.read || !rd_if.waitrequest) rd_leak++;
    end
    chk("rd32_third_stalled", rd_leak, 0);
    next_cyc();
    m_if.readdatavalid = 1'b0;
    @(negedge emif_br_clk);
    chk("rd32_drained", {m_if.read, rd_outstanding}, {1'b0, 7'd32});
    next_cyc();
    @(negedge emif_br_clk);
    chk("rd32_third_grant", m_if.read, 1'b1);

    // Write burst of 20 with three stall cycles before beat 5; reads pending must not break in.
    do_reset();
    wr_if.write = 1'b1; wr_if.burstcount = 6'd20;
    @(negedge emif_br_clk);
    chk("wr20_idle_c0", m_if.write, 1'b0);
    beats = 0; stalls = 0; wcyc = 0; rd_leak = 0; wait_bad = 0;
    for (int cyc = 0; cyc < 40 && beats < 20; cyc++) begin
      next_cyc();
      rd_if.read = 1'b1; rd_if.burstcount = 6'd4;
      m_if.waitrequest = (beats >= 4) && (stalls < 3);
      @(negedge emif_br_clk);
      if (m_if.read || !rd_if.waitrequest) rd_leak++;
      if (m_if.write) begin
        wcyc++;
        if (wr_if.waitrequest !== m_if.waitrequest) wait_bad++;
        if (m_if.waitrequest) stalls++;
        else beats++;
      end
    end
    chk("wr20_beats", beats, 20);
    chk("wr20_cycles", wcyc, 23);
    chk("wr20_no_read", rd_leak, 0);
    chk("wr20_waitreq", wait_bad, 0);
    next_cyc();
    wr_if.write = 1'b0; m_if.waitrequest = 1'b0;
    @(negedge emif_br_clk);
    chk("wr20_idle_after", {m_if.write, m_if.read, wr_if.waitrequest}, {1'b0, 1'b0, 1'b1});
    next_cyc();
    @(negedge emif_br_clk);
    chk("wr20_then_read", m_if.read, 1'b1);

    // Accept of 16 beats in the same cycle as a returned beat at cnt=10.
    do_reset();
    rd_if.read = 1'b1; rd_if.burstcount = 6'd10;
    next_cyc();
    next_cyc();
    rd_if.burstcount = 6'd16;
    next_cyc();
    m_if.readdatavalid = 1'b1;
    @(negedge emif_br_clk);
    chk("acc_ret_pre", {m_if.read, rd_outstanding}, {1'b1, 7'd10});
    next_cyc();
    rd_if.read = 1'b0; m_if.readdatavalid = 1'b0;
    @(negedge emif_br_clk);
    chk("acc_ret_cnt", rd_outstanding, 7'd25);

    // Asynchronous reset during write beat 3 of 8 with reads outstanding.
    do_reset();
    rd_if.read = 1'b1; rd_if.burstcount = 6'd5;
    next_cyc();
    next_cyc();
    rd_if.read = 1'b0; wr_if.write = 1'b1; wr_if.burstcount = 6'd8;
    repeat (3) next_cyc();
    @(negedge emif_br_clk);
    chk("rst_mid_pre", {m_if.write, rd_outstanding}, {1'b1, 7'd5});
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_async", ctrl_now(), CTRL_RESET);
    repeat (2) @(posedge emif_br_clk);
    #1 reset_n = 1'b1;
    wr_if.write = 1'b0; rd_if.read = 1'b1; rd_if.burstcount = 6'd4;
    @(negedge emif_br_clk);
    chk("rst_post_idle", {m_if.read, m_if.write, wr_if.waitrequest}, {1'b0, 1'b0, 1'b1});
    next_cyc();
    @(negedge emif_br_clk);
    chk("rst_post_grant", m_if.read, 1'b1);

    // Zero-length write request stays ungranted while reads keep flowing.
    do_reset();
    wr_if.write = 1'b1; wr_if.burstcount = 6'd0;
    rd_if.read = 1'b1; rd_if.burstcount = 6'd4;
    wr_seen = 0; rd_seen = 0; wrw_bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) next_cyc();
      @(negedge emif_br_clk);
      if (m_if.write) wr_seen++;
      if (m_if.read) rd_seen++;
      if (!wr_if.waitrequest) wrw_bad++;
    end
    chk("bc0_no_write", wr_seen, 0);
    chk("bc0_reads", rd_seen, 6);
    chk("bc0_wr_stalled", wrw_bad, 0);
    next_cyc();
    rd_if.read = 1'b0;
    @(negedge emif_br_clk);
    chk("bc0_cnt", rd_outstanding, 7'd24);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
